// File: rtl/regfile_pkg.sv
// Shared definitions for the 16x8 register file and its request sequencer:
// width defaults, request opcodes and sequencer state encoding.
package regfile_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ1 = 2'b01,
    OP_READ2 = 2'b10,
    OP_WRITE = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Sequences one operand-read / write-back request at a time onto the single register file port.
// Accept-to-response latency: READ1 2, READ2 3, WRITE 2 cycles; req_ready only in IDLE, response held until rsp_ready.
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr_a,
  input  logic [ADDR_W-1:0] req_addr_b,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data_a,
  output logic [DATA_W-1:0] rsp_data_b,
  output logic [ADDR_W-1:0] rf_address,
  output logic              rf_wr,
  output logic              rf_rd,
  output logic [DATA_W-1:0] rf_in_data,
  input  logic [DATA_W-1:0] rf_out_data,
  output logic              busy
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NOP;
      addr_a_q <= '0;
      addr_b_q <= '0;
      wdata_q  <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      wdata_q  <= wdata_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    wdata_d    = wdata_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rf_address = '0;
    rf_wr      = 1'b0;
    rf_rd      = 1'b0;
    rf_in_data = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d     = op_e'(req_op);
          addr_a_d = req_addr_a;
          addr_b_d = req_addr_b;
          wdata_d  = req_wdata;
          case (op_e'(req_op))
            OP_READ1, OP_READ2: state_d = ST_RD_A;
            OP_WRITE:           state_d = ST_WR;
            default:            state_d = ST_IDLE;
          endcase
        end
      end
      ST_RD_A: begin
        rf_address = addr_a_q;
        rf_rd      = 1'b1;
        data_a_d   = rf_out_data;
        // READ1 leaves operand B defined as zero; READ2 overwrites it next cycle.
        data_b_d   = '0;
        state_d    = (op_q == OP_READ2) ? ST_RD_B : ST_RESP;
      end
      ST_RD_B: begin
        rf_address = addr_b_q;
        rf_rd      = 1'b1;
        data_b_d   = rf_out_data;
        state_d    = ST_RESP;
      end
      ST_WR: begin
        rf_address = addr_a_q;
        rf_wr      = 1'b1;
        rf_in_data = wdata_q;
        data_a_d   = wdata_q;
        data_b_d   = '0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rsp_data_a = data_a_q;
  assign rsp_data_b = data_b_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer against a behavioural 16x8 register file.
module tb_regfile_sequencer;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_addr_a;
  logic [3:0] req_addr_b;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data_a;
  logic [7:0] rsp_data_b;
  logic [3:0] rf_address;
  logic       rf_wr;
  logic       rf_rd;
  logic [7:0] rf_in_data;
  logic [7:0] rf_out_data;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem [16];

  regfile_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b),
    .rf_address (rf_address),
    .rf_wr      (rf_wr),
    .rf_rd      (rf_rd),
    .rf_in_data (rf_in_data),
    .rf_out_data(rf_out_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: write lands at the edge, read is combinational on address.
  always @(posedge clk) begin
    if (rf_wr) mem[rf_address] <= rf_in_data;
  end
  assign rf_out_data = mem[rf_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in IDLE and returns one cycle after the accept edge.
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] wd);
    req_valid  = 1'b1;
    req_op     = op;
    req_addr_a = a;
    req_addr_b = b;
    req_wdata  = wd;
    chk("send_req_ready", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("hs_busy", 32'(busy), 0);
    chk("hs_rsp_valid", 32'(rsp_valid), 0);
    chk("hs_req_ready", 32'(req_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr_a = 4'd0;
    req_addr_b = 4'd0;
    req_wdata  = 8'h00;
    rsp_ready  = 1'b0;
    #1;

    // Reset values; a request presented during reset is not captured.
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rf_wr", 32'(rf_wr), 0);
    chk("rst_rf_rd", 32'(rf_rd), 0);
    chk("rst_rf_address", 32'(rf_address), 0);
    chk("rst_rf_in_data", 32'(rf_in_data), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_data_a", 32'(rsp_data_a), 0);
    chk("rst_data_b", 32'(rsp_data_b), 0);
    req_valid = 1'b1; req_op = 2'b11; req_addr_a = 4'd9; req_wdata = 8'h77;
    step();
    chk("rst_no_capture_busy", 32'(busy), 0);
    chk("rst_no_capture_wr", 32'(rf_wr), 0);
    req_valid = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // WRITE 3 <= A5
    send(2'b11, 4'd3, 4'd0, 8'hA5);
    chk("wr_rf_wr", 32'(rf_wr), 1);
    chk("wr_rf_address", 32'(rf_address), 3);
    chk("wr_rf_in_data", 32'(rf_in_data), 8'hA5);
    chk("wr_rsp_valid_early", 32'(rsp_valid), 0);
    chk("wr_req_ready_busy", 32'(req_ready), 0);
    step();
    chk("wr_rsp_valid", 32'(rsp_valid), 1);
    chk("wr_rf_wr_one_cycle", 32'(rf_wr), 0);
    chk("wr_rf_address_idle", 32'(rf_address), 0);
    chk("wr_data_a", 32'(rsp_data_a), 8'hA5);
    chk("wr_data_b", 32'(rsp_data_b), 0);
    chk("wr_req_ready_resp", 32'(req_ready), 0);
    handshake();

    // WRITE 7 <= 3C
    send(2'b11, 4'd7, 4'd0, 8'h3C);
    chk("wr7_rf_address", 32'(rf_address), 7);
    step();
    chk("wr7_data_a", 32'(rsp_data_a), 8'h3C);
    handshake();

    // READ2 a=3 b=7
    send(2'b10, 4'd3, 4'd7, 8'h00);
    chk("r2_rd_a_rf_rd", 32'(rf_rd), 1);
    chk("r2_rd_a_addr", 32'(rf_address), 3);
    chk("r2_rd_a_rsp_valid", 32'(rsp_valid), 0);
    step();
    chk("r2_rd_b_rf_rd", 32'(rf_rd), 1);
    chk("r2_rd_b_addr", 32'(rf_address), 7);
    chk("r2_rd_b_rsp_valid", 32'(rsp_valid), 0);
    step();
    chk("r2_rsp_valid", 32'(rsp_valid), 1);
    chk("r2_rf_rd_off", 32'(rf_rd), 0);
    chk("r2_data_a", 32'(rsp_data_a), 8'hA5);
    chk("r2_data_b", 32'(rsp_data_b), 8'h3C);
    handshake();

    // READ1 a=7 with response backpressure for 5 cycles
    send(2'b01, 4'd7, 4'd3, 8'h00);
    chk("r1_rf_rd", 32'(rf_rd), 1);
    chk("r1_addr", 32'(rf_address), 7);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_data_a", 32'(rsp_data_a), 8'h3C);
      chk("bp_data_b", 32'(rsp_data_b), 0);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_rf_rd", 32'(rf_rd), 0);
      chk("bp_rf_wr", 32'(rf_wr), 0);
      step();
    end
    chk("bp_still_valid", 32'(rsp_valid), 1);
    handshake();

    // Boundary addresses 15 and 0, READ2 with both sources equal
    send(2'b11, 4'd15, 4'd0, 8'hFF);
    chk("wr15_addr", 32'(rf_address), 15);
    step();
    handshake();
    send(2'b11, 4'd0, 4'd0, 8'h01);
    chk("wr0_addr", 32'(rf_address), 0);
    chk("wr0_in_data", 32'(rf_in_data), 8'h01);
    step();
    handshake();
    send(2'b10, 4'd15, 4'd15, 8'h00);
    chk("r2same_a_addr", 32'(rf_address), 15);
    step();
    chk("r2same_b_addr", 32'(rf_address), 15);
    chk("r2same_b_rd", 32'(rf_rd), 1);
    step();
    chk("r2same_data_a", 32'(rsp_data_a), 8'hFF);
    chk("r2same_data_b", 32'(rsp_data_b), 8'hFF);
    handshake();
    send(2'b01, 4'd0, 4'd15, 8'h00);
    step();
    chk("r1zero_rsp_valid", 32'(rsp_valid), 1);
    chk("r1zero_data_a", 32'(rsp_data_a), 8'h01);
    chk("r1zero_data_b", 32'(rsp_data_b), 0);
    handshake();

    // req_valid held: NOP, then WRITE 5 <= 5A, then READ1 5
    req_valid = 1'b1; req_op = 2'b00; req_addr_a = 4'd5; req_addr_b = 4'd0; req_wdata = 8'hEE;
    chk("nop_req_ready", 32'(req_ready), 1);
    step();
    chk("nop_busy", 32'(busy), 0);
    chk("nop_rsp_valid", 32'(rsp_valid), 0);
    chk("nop_rf_wr", 32'(rf_wr), 0);
    req_op = 2'b11; req_wdata = 8'h5A;
    step();
    chk("held_wr_busy", 32'(busy), 1);
    chk("held_wr_rf_wr", 32'(rf_wr), 1);
    chk("held_wr_in_data", 32'(rf_in_data), 8'h5A);
    req_op = 2'b01; req_wdata = 8'h00;
    chk("held_wr_req_ready", 32'(req_ready), 0);
    step();
    chk("held_resp_valid", 32'(rsp_valid), 1);
    chk("held_resp_req_ready", 32'(req_ready), 0);
    chk("held_resp_data_a", 32'(rsp_data_a), 8'h5A);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("held_idle_busy", 32'(busy), 0);
    chk("held_idle_req_ready", 32'(req_ready), 1);
    chk("held_idle_rsp_valid", 32'(rsp_valid), 0);
    step();
    req_valid = 1'b0;
    chk("held_r1_rf_rd", 32'(rf_rd), 1);
    chk("held_r1_addr", 32'(rf_address), 5);
    step();
    chk("held_r1_rsp_valid", 32'(rsp_valid), 1);
    chk("held_r1_data_a", 32'(rsp_data_a), 8'h5A);
    handshake();

    // Reset asserted during RD_B of a READ2
    send(2'b10, 4'd3, 4'd7, 8'h00);
    step();
    chk("mid_rd_b_addr", 32'(rf_address), 7);
    chk("mid_rd_b_rd", 32'(rf_rd), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rf_rd", 32'(rf_rd), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    step();
    chk("mid_rst_next_busy", 32'(busy), 0);
    chk("mid_rst_next_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_next_rf_rd", 32'(rf_rd), 0);
    chk("mid_rst_data_a", 32'(rsp_data_a), 0);
    reset_n = 1'b1;
    step();
    send(2'b01, 4'd3, 4'd0, 8'h00);
    chk("post_rst_rf_rd", 32'(rf_rd), 1);
    chk("post_rst_addr", 32'(rf_address), 3);
    step();
    chk("post_rst_rsp_valid", 32'(rsp_valid), 1);
    chk("post_rst_data_a", 32'(rsp_data_a), 8'hA5);
    chk("post_rst_data_b", 32'(rsp_data_b), 0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
